// File: rtl/decoder_pkg.sv
// Shared constants, parity function and pipeline bundle for the
// 7-bit data / 12-bit codeword parity decoder.
package decoder_pkg;

   localparam int DATA_W = 7;
   localparam int CODE_W = 12;
   localparam int SYN_W  = 5;

   localparam int P7_IDX  = 7;
   localparam int P8_IDX  = 8;
   localparam int P9_IDX  = 9;
   localparam int P10_IDX = 10;
   localparam int P11_IDX = 11;

   // Returns {p11,p10,p9,p8,p7}; p9 and p10 are the same equation.
   function automatic logic [SYN_W-1:0] parity_of(
      input logic [DATA_W-1:0] b
   );
      logic p7, p8, p9, p11;
      p7  = b[0] ^ b[1] ^ b[5] ^ b[6];
      p8  = b[0] ^ b[2] ^ b[4] ^ b[5];
      p9  = b[0] ^ b[1] ^ b[3] ^ b[5] ^ b[6];
      p11 = b[1] ^ b[3] ^ b[5] ^ b[6];
      return {p11, p9, p9, p8, p7};
   endfunction

   typedef struct packed {
      logic [DATA_W-1:0] b;
      logic [SYN_W-1:0]  syn;
      logic              err;
      logic              dup_err;
   } s2_t;

endpackage

// File: rtl/decoder_if.sv
// Input codeword stream and output result stream of the decoder.
interface decoder_if;
   import decoder_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_c;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_b;
   logic [SYN_W-1:0]  out_syn;
   logic              out_err;
   logic              out_dup_err;

   modport master (
      output in_valid, in_c, out_ready,
      input  in_ready, out_valid, out_b,
      input  out_syn, out_err, out_dup_err
   );

   modport slave (
      input  in_valid, in_c, out_ready,
      output in_ready, out_valid, out_b,
      output out_syn, out_err, out_dup_err
   );

endinterface

// File: rtl/decoder_syndrome_calc.sv
// Combinational syndrome and error flags for one received codeword.
module syndrome_calc
   import decoder_pkg::*;
(
   input  logic [CODE_W-1:0] i_c,
   output logic [SYN_W-1:0]  o_syn,
   output logic              o_err,
   output logic              o_dup_err
);

   logic [SYN_W-1:0] w_rx_par;
   logic [SYN_W-1:0] w_calc_par;

   assign w_rx_par = {i_c[P11_IDX], i_c[P10_IDX], i_c[P9_IDX],
                      i_c[P8_IDX], i_c[P7_IDX]};

   assign w_calc_par = parity_of(i_c[DATA_W-1:0]);

   assign o_syn     = w_rx_par ^ w_calc_par;
   assign o_err     = |o_syn;
   assign o_dup_err = i_c[P9_IDX] ^ i_c[P10_IDX];

endmodule

// File: rtl/decoder.sv
// Two-stage detect-only parity decoder with valid/ready backpressure
// and a saturating error counter with sticky flag.
module decoder
   import decoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   decoder_if.slave         bus,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sticky
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_s1_valid;
   logic [CODE_W-1:0] r_s1_c;
   logic              r_s2_valid;
   s2_t               r_s2;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sticky;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_err_xfer;
   logic [SYN_W-1:0]  w_syn;
   logic              w_err;
   logic              w_dup_err;

   // in_ready follows out_ready combinationally through both stages.
   assign w_s2_adv = !r_s2_valid || bus.out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;

   assign bus.in_ready = w_s1_adv;

   syndrome_calc u_syn (
      .i_c       (r_s1_c),
      .o_syn     (w_syn),
      .o_err     (w_err),
      .o_dup_err (w_dup_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_c     <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid)
            r_s1_c <= bus.in_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2       <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2.b       <= r_s1_c[DATA_W-1:0];
            r_s2.syn     <= w_syn;
            r_s2.err     <= w_err;
            r_s2.dup_err <= w_dup_err;
         end
      end
   end

   assign w_err_xfer = r_s2_valid && bus.out_ready && r_s2.err;

   // clr wins over a same-cycle error transfer; that word is dropped.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (w_err_xfer) begin
         r_sticky <= 1'b1;
         if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.out_valid   = r_s2_valid;
   assign bus.out_b       = r_s2.b;
   assign bus.out_syn     = r_s2.syn;
   assign bus.out_err     = r_s2.err;
   assign bus.out_dup_err = r_s2.dup_err;

   assign err_cnt    = r_cnt;
   assign err_sticky = r_sticky;

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Receive-side companion to the 7-bit to 12-bit parity encoder.
- Accepts 12-bit codewords over a valid/ready stream and recomputes the five parity bits from the 7 data bits.
- Emits the data, a 5-bit syndrome and error flags through a 2-stage registered pipeline with full backpressure.
- Keeps a saturating error counter and a sticky error flag for status readout.
- Detect-only: the code's parity-check columns are not unique (data bits b2 and b4 both map to c8 only), so no correction is attempted.

Parameters:
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  codeword on in_c is valid.
- in_ready  out  1  decoder can accept in_c this cycle.
- in_c  in  12  received codeword: [6:0] data, [11:7] parity.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts this cycle.
- out_b  out  7  data bits, equal to in_c[6:0] unmodified.
- out_syn  out  5  syndrome {s4,s3,s2,s1,s0}.
- out_err  out  1  out_syn is nonzero.
- out_dup_err  out  1  received c9 is not equal to received c10.
- err_cnt  out  CNT_W  count of accepted words with out_err=1, saturating.
- err_sticky  out  1  set by any error word; cleared only by clr or rst.
- clr  in  1  synchronous clear of err_cnt and err_sticky.

Behaviour:
- Parity equations (b = c[6:0]):
  - p7 = b0^b1^b5^b6
  - p8 = b0^b2^b4^b5
  - p9 = p10 = b0^b1^b3^b5^b6
  - p11 = b1^b3^b5^b6
- Syndrome: s0=c7^p7, s1=c8^p8, s2=c9^p9, s3=c10^p10, s4=c11^p11.
- Flags: out_err = |s. out_dup_err = c9^c10.
- Pipeline stages:
  - S1 registers in_c and a valid bit.
  - S2 registers b, syn, err, dup_err and a valid bit; S2 drives the out_* ports.
  - Syndrome is computed combinationally between S1 and S2.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances; it is combinational from out_ready (an accepted ready-path constraint).
- Latency: 2 cycles from input accept to out_valid when there is no stall. Throughput is 1 word per cycle.
- Stall: when out_ready=0 with both stages full, out_* hold stable and in_ready=0. No word is lost or duplicated.
- Data stability: out_valid must not drop and out_* must not change until the transfer completes.
- Counter and sticky flag:
  - Updated on output transfer (out_valid && out_ready && out_err).
  - err_cnt saturates at 2^CNT_W-1.
  - err_sticky is set on the same event.
  - clr has priority over a same-cycle update: the result is err_cnt=0 and err_sticky=0, and that word is not counted.
- Reset (rst=1): s1_valid=0, s2_valid=0, out_valid=0, in_ready=1 on the cycle after reset, out_b=0, out_syn=0, out_err=0, out_dup_err=0, err_cnt=0, err_sticky=0.
- Reset mid-stream: in-flight words are discarded, not delivered.
- Any input is accepted, including codewords with parity errors.

Decomposition:
- Shared package (decoder_pkg) holds:
  - constants DATA_W=7, CODE_W=12, SYN_W=5;
  - function parity_of(b) returning the 5 parity bits, shared with encoder checks;
  - index constants for the parity positions 7 to 11.
- One sub-module, syndrome_calc: combinational, input 12-bit codeword, outputs syn, err and dup_err; instantiated between S1 and S2.

Test Plan:
- Clean words: in_c=12'h000, then 12'h67F (b=7'h7F), then 12'h781 (b=7'h01) back-to-back with out_ready=1 -> out_b=00, 7F, 01; out_syn=0; out_err=0; each appears exactly 2 cycles after accept; err_cnt=0.
- Data error: in_c=12'h780 (bit0 of 12'h781 flipped) -> out_b=7'h00, out_syn=5'b01111, out_err=1, out_dup_err=0, err_cnt=1, err_sticky=1.
- Duplicate mismatch: in_c=12'h400 -> out_syn=5'b01000, out_err=1, out_dup_err=1.
- Backpressure: stream 4 words, hold out_ready=0 for 5 cycles -> in_ready=0 once 2 words are held, out_* stable throughout; after release all 4 words emerge in order with none lost.
- Saturation and clear: CNT_W=2, send 5 error words -> err_cnt stays at 3. Assert clr on the same cycle as an error transfer -> err_cnt=0, err_sticky=0.
- Reset mid-stream: rst=1 while both stages are valid -> next cycle out_valid=0, all outputs 0; the first post-reset word appears 2 cycles after its accept.
